// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider controller.
package div_seq_ctrl_pkg;

    localparam int W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Execute-stage <-> divider request/result bundle.
// start is a request sampled only when the divider is not busy; done is a one-cycle
// pulse, and quotient/remainder/div_by_zero stay valid from done until the next accept.
interface div_seq_ctrl_if
    import div_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl_sub.sv
// ALU ripple subtractor: out = a - b, cout = 1 iff a >= b (no borrow).
module sub
    import div_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out,
    output logic         cout
);

    // a + ~b + 1, rippled bit by bit
    always_comb begin
        logic carry;
        carry = 1'b1;
        out   = '0;
        for (int i = 0; i < W; i++) begin
            out[i] = a[i] ^ ~b[i] ^ carry;
            carry  = (a[i] & ~b[i]) | ((a[i] ^ ~b[i]) & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider controller; one quotient bit per cycle
// using a single shared W-bit subtractor.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_ctrl_if.slave  bus,
    output state_t         dbg_state
);

    localparam int             CW   = $clog2(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  r, q, d;
    logic [W-1:0]  rs, diff, r_nxt, q_nxt;
    logic          c, cout, take;
    logic          accept, div0;
    logic [W-1:0]  quo, rem;
    logic          dz;

    // Shifted partial remainder; c is the bit pushed out of R's MSB
    assign rs    = {r[W-2:0], q[W-1]};
    assign c     = r[W-1];
    assign take  = c | cout;
    assign r_nxt = take ? diff : rs;
    assign q_nxt = {q[W-2:0], take};

    assign accept = bus.start && (state != RUN);
    assign div0   = (bus.divisor == '0);

    sub #(.W(W)) u_sub (
        .a    (rs),
        .b    (d),
        .out  (diff),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = div0 ? DONE : RUN;
            RUN:  if (cnt == LAST) state_nxt = DONE;
            DONE: begin
                if (bus.start) state_nxt = div0 ? DONE : RUN;
                else           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            r   <= '0;
            q   <= '0;
            d   <= '0;
            quo <= '0;
            rem <= '0;
            dz  <= 1'b0;
        end else if (accept) begin
            if (div0) begin
                quo <= '1;
                rem <= bus.dividend;
                dz  <= 1'b1;
            end else begin
                cnt <= '0;
                r   <= '0;
                q   <= bus.dividend;
                d   <= bus.divisor;
            end
        end else if (state == RUN) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                quo <= q_nxt;
                rem <= r_nxt;
                dz  <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dz;
    assign dbg_state       = state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed plus randomized bench for div_seq_ctrl, checked against plain / and %.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    localparam int W = 64;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    div_seq_ctrl_if #(.W(W)) bus();

    div_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;
    int acc_cyc = 0;

    // Scoreboard: each accepted op pushes quotient, remainder, div_by_zero
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) begin
            exp_q.push_back('1);
            exp_q.push_back(a);
            exp_q.push_back(W'(1));
        end else begin
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
            exp_q.push_back(W'(0));
        end
    endtask

    // Present a request for one edge, then scramble the operand bus
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        model_push(a, b);
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.start    = 1'b0;
        bus.dividend = rnd64();
        bus.divisor  = rnd64();
    endtask

    task automatic wait_done(input string tag, input int lat);
        while (!bus.done && (cyc - acc_cyc) < W + 10) begin
            @(posedge clk);
            #1;
        end
        check({tag, " latency"}, W'(cyc - acc_cyc), W'(lat));
        check({tag, " done"}, W'(bus.done), W'(1));
        check({tag, " busy"}, W'(bus.busy), W'(0));
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] eq, er, ez;
        if (exp_q.size() < 3) begin
            check({tag, " scoreboard depth"}, W'(exp_q.size()), W'(3));
        end else begin
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            ez = exp_q.pop_front();
            check({tag, " quotient"}, bus.quotient, eq);
            check({tag, " remainder"}, bus.remainder, er);
            check({tag, " div_by_zero"}, W'(bus.div_by_zero), ez);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b);
        wait_done(tag, (b == '0) ? 0 : W);
        check_result(tag);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int mode;

        // Clock/reset
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset quotient", bus.quotient, W'(0));
        check("reset remainder", bus.remainder, W'(0));
        check("reset div_by_zero", W'(bus.div_by_zero), W'(0));
        check("reset state", W'(dbg_state), W'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with busy during run and hold after the done pulse
        issue(W'(100), W'(7));
        check("100/7 busy", W'(bus.busy), W'(1));
        wait_done("100/7", W);
        check_result("100/7");
        @(posedge clk);
        #1;
        check("done pulse width", W'(bus.done), W'(0));
        check("hold quotient", bus.quotient, W'(14));
        check("hold remainder", bus.remainder, W'(2));

        // Shifted-out MSB path
        run_op("max/2^63+1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);

        // Divide by zero
        run_op("5/0", W'(5), W'(0));

        // Back-to-back: start during DONE
        run_op("3/10", W'(3), W'(10));
        issue(W'(1), W'(1));
        check("b2b done drops", W'(bus.done), W'(0));
        check("b2b busy", W'(bus.busy), W'(1));
        wait_done("1/1", W);
        check_result("1/1");

        // Start during RUN is ignored
        a = rnd64();
        b = rnd64() >> $urandom_range(0, 40);
        if (b == '0) b = W'(3);
        issue(a, b);
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = rnd64();
        bus.divisor  = W'(1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ignored start busy", W'(bus.busy), W'(1));
        wait_done("ignored start", W);
        check_result("ignored start");

        // Reset mid-RUN
        issue(rnd64(), W'(9));
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", W'(bus.busy), W'(0));
        check("abort done", W'(bus.done), W'(0));
        check("abort quotient", bus.quotient, W'(0));
        check("abort remainder", bus.remainder, W'(0));
        check("abort div_by_zero", W'(bus.div_by_zero), W'(0));
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort no done", W'(bus.done), W'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort idle done", W'(bus.done), W'(0));
        check("abort idle busy", W'(bus.busy), W'(0));

        // Randomized operations with occasional idle gaps
        for (int i = 0; i < 25; i++) begin
            mode = $urandom_range(0, 7);
            case (mode)
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 255));
                3, 4:    b = W'($urandom());
                default: b = rnd64() >> $urandom_range(0, 63);
            endcase
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : rnd64();
            run_op("random", a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
